// File: rtl/sonar_tof_capture_pkg.sv
// Shared types and constants for the sonar time-of-flight capture block:
// FSM state encoding, register word addresses, CTRL/STATUS bit positions
// and the reset defaults of the BLANK and WINDOW registers.
package sonar_tof_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BLANKING = 2'd1,
        ST_LISTEN   = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    // Word addresses on the per-slave register bus
    localparam logic [4:0] ADR_CTRL     = 5'd0;
    localparam logic [4:0] ADR_STATUS   = 5'd1;
    localparam logic [4:0] ADR_BLANK    = 5'd2;
    localparam logic [4:0] ADR_WINDOW   = 5'd3;
    localparam logic [4:0] ADR_TICK     = 5'd4;
    localparam logic [4:0] ADR_TOF_BASE = 5'd16;

    // CTRL bits
    localparam int CTRL_START     = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int CTRL_CONT      = 2;
    localparam int CTRL_ABORT     = 3;
    localparam int CTRL_STATE_LSB = 4;

    // STATUS bits
    localparam int STATUS_DONE = 15;

    // Register reset defaults
    localparam logic [15:0] BLANK_RST  = 16'h0010;
    localparam logic [15:0] WINDOW_RST = 16'h0800;

endpackage

// File: rtl/sonar_tof_capture_if.sv
// Register bus shared with the SonarOnChip slaves: one-cycle valid strobe,
// word address, write data / write flag, and a registered ack + read data.
interface sonar_tof_capture_if;
    logic        wb_valid_i;
    logic [4:0]  wbs_adr_i;
    logic [15:0] wbs_dat_i;
    logic        wbs_strb_i;
    logic        wbs_ack_o;
    logic [15:0] wbs_dat_o;

    modport slave (
        input  wb_valid_i, wbs_adr_i, wbs_dat_i, wbs_strb_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wb_valid_i, wbs_adr_i, wbs_dat_i, wbs_strb_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/sonar_tof_capture_chan.sv
// One sonar channel: rising-edge detect on the comparator flag, a sticky
// hit flag and the TOF latch that captures the tick count on the first hit.
module sonar_tof_chan #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,      // new measurement: forget hit and TOF
    input  logic             listen,   // hits are only accepted while listening
    input  logic             cmp,
    input  logic [CNT_W-1:0] tick,
    output logic             hit,
    output logic [CNT_W-1:0] tof
);

    logic             cmp_q;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] tof_q, tof_d;
    logic             edge_hit;

    // cmp_q tracks cmp in every state, so a level already high when
    // listening starts is not mistaken for an edge.
    assign edge_hit = listen & cmp & ~cmp_q & ~hit_q;

    // Only the first edge per measurement is latched
    always_comb begin
        hit_d = hit_q;
        tof_d = tof_q;
        if (clr) begin
            hit_d = 1'b0;
            tof_d = '0;
        end else if (edge_hit) begin
            hit_d = 1'b1;
            tof_d = tick;
        end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q <= 1'b0;
            hit_q <= 1'b0;
            tof_q <= '0;
        end else begin
            cmp_q <= cmp;
            hit_q <= hit_d;
            tof_q <= tof_d;
        end
    end

    assign hit = hit_q;
    assign tof = tof_q;

endmodule

// File: rtl/sonar_tof_capture.sv
// Sonar time-of-flight capture: counts ce_pcm ticks from a software START,
// blanks the first BLANK ticks, then latches per-channel TOF on the first
// cmp rising edge until every channel hit or WINDOW expires. Results and
// control live on the shared register bus; irq_o flags completion.
// Optional build macro SSCS_TOF_AUTO_REARM_EN adds CTRL.CONT, which makes
// DONE restart a new measurement automatically one cycle after entry.
module sonar_tof_capture
    import sonar_tof_pkg::*;
#(
    parameter int N_CH  = 15,
    parameter int CNT_W = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    sonar_tof_capture_if.slave  bus,
    input  logic                ce_pcm,
    input  logic [N_CH-1:0]     cmp,
    output logic                irq_o
);

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            tick_q, tick_d;
    logic [CNT_W-1:0]            blank_q, blank_d;
    logic [CNT_W-1:0]            window_q, window_d;
    logic                        irq_en_q, irq_en_d;
    logic                        done_q, done_d;
    logic                        ack_q, ack_d;
    logic [15:0]                 dat_q, dat_d;
    logic                        cont;

    logic [N_CH-1:0]             hit_mask;
    logic [N_CH-1:0][CNT_W-1:0]  tof;

    logic                        wr, ctrl_wr, start, abort, status_clr;
    logic                        cnt_en, listen_en, rearm, restart;
    logic [15:0]                 rdata;

    // Bus write decode; ABORT wins over START in the same write
    assign wr         = bus.wb_valid_i & bus.wbs_strb_i;
    assign ctrl_wr    = wr && (bus.wbs_adr_i == ADR_CTRL);
    assign start      = ctrl_wr & bus.wbs_dat_i[CTRL_START] & ~bus.wbs_dat_i[CTRL_ABORT];
    assign abort      = ctrl_wr & bus.wbs_dat_i[CTRL_ABORT];
    assign status_clr = wr && (bus.wbs_adr_i == ADR_STATUS) && bus.wbs_dat_i[STATUS_DONE];
    assign restart    = ~abort & (start | rearm);

`ifdef SSCS_TOF_AUTO_REARM_EN
    logic cont_q, cont_d;

    // Continuous-mode bit, written with every CTRL write
    always_comb begin
        cont_d = cont_q;
        if (ctrl_wr) cont_d = bus.wbs_dat_i[CTRL_CONT];
    end

    // Continuous-mode register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) cont_q <= 1'b0;
        else             cont_q <= cont_d;
    end

    assign cont = cont_q;
`else
    assign cont = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    // FSM next state: software commands override the measurement flow
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_BLANKING;
        end else begin
            case (state_q)
                ST_BLANKING: if (ce_pcm && tick_q >= blank_q) state_d = ST_LISTEN;
                ST_LISTEN:   if ((&hit_mask) || (ce_pcm && tick_q >= window_q)) state_d = ST_DONE;
                ST_DONE:     if (cont) state_d = ST_BLANKING;
                default:     ;
            endcase
        end
    end

    // FSM outputs: counting, hit acceptance and auto re-arm
    always_comb begin
        cnt_en    = 1'b0;
        listen_en = 1'b0;
        rearm     = 1'b0;
        case (state_q)
            ST_BLANKING: cnt_en = 1'b1;
            ST_LISTEN: begin
                cnt_en    = 1'b1;
                listen_en = ~abort;
            end
            ST_DONE:     rearm = cont;
            default:     ;
        endcase
    end

    // Per-channel edge detect and TOF latches
    for (genvar n = 0; n < N_CH; n++) begin : g_chan
        sonar_tof_chan #(.CNT_W(CNT_W)) u_chan (
            .clk    (wb_clk_i),
            .rst_n  (wb_rst_n_i),
            .clr    (restart),
            .listen (listen_en),
            .cmp    (cmp[n]),
            .tick   (tick_q),
            .hit    (hit_mask[n]),
            .tof    (tof[n])
        );
    end

    // Read mux: values as they stand before this cycle's write lands
    always_comb begin
        rdata = '0;
        case (bus.wbs_adr_i)
            ADR_CTRL: begin
                rdata[CTRL_STATE_LSB +: 2] = state_q;
                rdata[CTRL_IRQ_EN]         = irq_en_q;
                rdata[CTRL_CONT]           = cont;
            end
            ADR_STATUS: begin
                rdata[N_CH-1:0]   = hit_mask;
                rdata[STATUS_DONE] = done_q;
            end
            ADR_BLANK:  rdata = 16'(blank_q);
            ADR_WINDOW: rdata = 16'(window_q);
            ADR_TICK:   rdata = 16'(tick_q);
            default: begin
                for (int n = 0; n < N_CH; n++) begin
                    if (bus.wbs_adr_i == ADR_TOF_BASE + 5'(n)) rdata = 16'(tof[n]);
                end
            end
        endcase
    end

    // Datapath next values: counter, config registers, done flag, bus reply
    always_comb begin
        tick_d   = tick_q;
        blank_d  = blank_q;
        window_d = window_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;

        if (restart) begin
            tick_d = '0;
        end else if (cnt_en && ce_pcm && !abort && tick_q != '1) begin
            tick_d = tick_q + 1'b1;  // saturating
        end

        if (ctrl_wr) irq_en_d = bus.wbs_dat_i[CTRL_IRQ_EN];
        if (wr && bus.wbs_adr_i == ADR_BLANK)  blank_d  = bus.wbs_dat_i[CNT_W-1:0];
        if (wr && bus.wbs_adr_i == ADR_WINDOW) window_d = bus.wbs_dat_i[CNT_W-1:0];

        if (restart) begin
            done_d = 1'b0;
        end else if (state_q == ST_LISTEN && state_d == ST_DONE) begin
            done_d = 1'b1;
        end else if (status_clr) begin
            done_d = 1'b0;
        end

        ack_d = bus.wb_valid_i;
        dat_d = (bus.wb_valid_i && !bus.wbs_strb_i) ? rdata : 16'h0;
    end

    // Datapath registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            tick_q   <= '0;
            blank_q  <= BLANK_RST[CNT_W-1:0];
            window_q <= WINDOW_RST[CNT_W-1:0];
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= 16'h0;
        end else begin
            tick_q   <= tick_d;
            blank_q  <= blank_d;
            window_q <= window_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = dat_q;
    assign irq_o         = done_q & irq_en_q;

endmodule

// File: tb/tb_sonar_tof_capture.sv
// Directed bench for sonar_tof_capture: register traffic is expressed as
// tables of {write/read, address, data-or-expected} records, ce_pcm and cmp
// are driven in hand-written sequences around them.
module tb_sonar_tof_capture;
    import sonar_tof_pkg::*;

    localparam int N_CH  = 15;
    localparam int CNT_W = 16;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            ce    = 1'b0;
    logic [N_CH-1:0] cmp   = '0;
    logic            irq;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    typedef struct {
        logic        wr;
        logic [4:0]  adr;
        logic [15:0] dat;   // write data, or expected read data
        string       name;
    } vec_t;

    vec_t tbl[$];

    sonar_tof_capture_if bus();

    sonar_tof_capture #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus),
        .ce_pcm     (ce),
        .cmp        (cmp),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int k);
        ce = 1'b1;
        repeat (k) cyc();
        ce = 1'b0;
    endtask

    task automatic bus_op(input logic wr, input logic [4:0] adr, input logic [15:0] dat,
                          input string nm);
        bus.wb_valid_i = 1'b1;
        bus.wbs_strb_i = wr;
        bus.wbs_adr_i  = adr;
        bus.wbs_dat_i  = wr ? dat : 16'h0;
        cyc();
        bus.wb_valid_i = 1'b0;
        chk({nm, " ack"}, 16'(bus.wbs_ack_o), 16'h0001);
        if (!wr) chk(nm, bus.wbs_dat_o, dat);
    endtask

    task automatic add(input logic wr, input logic [4:0] adr, input logic [15:0] dat,
                       input string nm);
        vec_t v;
        v.wr = wr; v.adr = adr; v.dat = dat; v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) bus_op(tbl[i].wr, tbl[i].adr, tbl[i].dat, tbl[i].name);
        tbl.delete();
    endtask

    task automatic add_reset_reads(input string tag);
        add(0, ADR_CTRL,   16'h0000, {tag, " ctrl"});
        add(0, ADR_STATUS, 16'h0000, {tag, " status"});
        add(0, ADR_BLANK,  16'h0010, {tag, " blank"});
        add(0, ADR_WINDOW, 16'h0800, {tag, " window"});
        add(0, ADR_TICK,   16'h0000, {tag, " tick"});
        add(0, 5'd16,      16'h0000, {tag, " tof0"});
        add(0, 5'd30,      16'h0000, {tag, " tof14"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N_CH-1:0] all_ch;
        all_ch = '1;
        bus.wb_valid_i = 1'b0;
        bus.wbs_strb_i = 1'b0;
        bus.wbs_adr_i  = 5'd0;
        bus.wbs_dat_i  = 16'h0;

        #12 rst_n = 1'b1;
        cyc();

        // Reset state
        chk("rst irq", 16'(irq), 16'h0);
        chk("rst ack", 16'(bus.wbs_ack_o), 16'h0);
        chk("rst dat", bus.wbs_dat_o, 16'h0);
        add_reset_reads("rst");
        add(1, 5'd5,  16'hFFFF, "unmapped wr");
        add(0, 5'd5,  16'h0000, "unmapped rd5");
        add(0, 5'd31, 16'h0000, "unmapped rd31");
        add(0, ADR_BLANK, 16'h0010, "blank after unmapped wr");
        run_tbl();

        // Back-to-back reads: one ack each, data zero outside ack
        bus.wb_valid_i = 1'b1; bus.wbs_strb_i = 1'b0; bus.wbs_adr_i = ADR_BLANK;
        cyc();
        chk("b2b ack0", 16'(bus.wbs_ack_o), 16'h1);
        chk("b2b dat0", bus.wbs_dat_o, 16'h0010);
        bus.wbs_adr_i = ADR_WINDOW;
        cyc();
        bus.wb_valid_i = 1'b0;
        chk("b2b ack1", 16'(bus.wbs_ack_o), 16'h1);
        chk("b2b dat1", bus.wbs_dat_o, 16'h0800);
        cyc();
        chk("b2b idle ack", 16'(bus.wbs_ack_o), 16'h0);
        chk("b2b idle dat", bus.wbs_dat_o, 16'h0);

        // Two channels hit, then window expiry with IRQ enabled
        add(1, ADR_BLANK,  16'd4,   "s1 blank");
        add(1, ADR_WINDOW, 16'd100, "s1 window");
        add(1, ADR_CTRL,   16'h0003, "s1 start");
        run_tbl();
        pulses(20);
        cmp[0] = 1'b1; pulses(1);
        pulses(29);
        cmp[3] = 1'b1; pulses(1);
        pulses(49);
        chk("s1 irq before window", 16'(irq), 16'h0);
        pulses(1);
        chk("s1 irq at window", 16'(irq), 16'h1);
        add(0, ADR_STATUS, 16'h8009, "s1 status");
        add(0, 5'd16,      16'd20,   "s1 tof0");
        add(0, 5'd19,      16'd50,   "s1 tof3");
        add(0, 5'd17,      16'd0,    "s1 tof1");
        add(0, ADR_CTRL,   16'h0032, "s1 ctrl");
        run_tbl();

        // Level high across blanking is not a hit; a later edge is
        cmp = '0; cmp[2] = 1'b1;
        add(1, ADR_BLANK, 16'd8,    "s2 blank");
        add(1, ADR_CTRL,  16'h0003, "s2 start");
        run_tbl();
        pulses(12);
        add(0, ADR_STATUS, 16'h0000, "s2 no hit");
        add(0, ADR_TICK,   16'd12,   "s2 tick");
        run_tbl();
        cmp[2] = 1'b0; pulses(1);
        pulses(17);
        cmp[2] = 1'b1; pulses(1);
        add(0, 5'd18,      16'd30,   "s2 tof2");
        add(0, ADR_STATUS, 16'h0004, "s2 status");
        run_tbl();

        // All channels together end the measurement early
        cmp = '0;
        add(1, ADR_CTRL, 16'h0003, "s3 start");
        run_tbl();
        pulses(40);
        cmp = all_ch;
        cyc();
        chk("s3 irq hit cycle", 16'(irq), 16'h0);
        cyc();
        chk("s3 irq next cycle", 16'(irq), 16'h1);
        add(0, ADR_STATUS, 16'hFFFF, "s3 status");
        add(0, 5'd16,      16'd40,   "s3 tof0");
        add(0, 5'd30,      16'd40,   "s3 tof14");
        add(0, ADR_CTRL,   16'h0032, "s3 ctrl");
        run_tbl();

        // Re-hit ignored, hit on the window tick captured, done clear, abort
        cmp = '0;
        add(1, ADR_WINDOW, 16'd60,   "s4 window");
        add(1, ADR_CTRL,   16'h0003, "s4 start");
        run_tbl();
        pulses(20);
        cmp[1] = 1'b1; pulses(1);
        cmp[1] = 1'b0; pulses(1);
        cmp[1] = 1'b1; pulses(1);
        pulses(37);
        cmp[5] = 1'b1; pulses(1);
        chk("s4 irq", 16'(irq), 16'h1);
        add(0, 5'd17,      16'd20,   "s4 tof1 kept");
        add(0, 5'd21,      16'd60,   "s4 tof5 boundary");
        add(0, ADR_STATUS, 16'h8022, "s4 status");
        add(1, ADR_STATUS, 16'h8000, "s4 clear done");
        run_tbl();
        chk("s4 irq cleared", 16'(irq), 16'h0);
        add(0, ADR_STATUS, 16'h0022, "s4 status cleared");
        add(1, ADR_CTRL,   16'h000A, "s4 abort");
        add(0, ADR_CTRL,   16'h0002, "s4 ctrl idle");
        add(1, ADR_CTRL,   16'h000B, "s4 start+abort");
        add(0, ADR_CTRL,   16'h0002, "s4 ctrl still idle");
        add(0, ADR_STATUS, 16'h0022, "s4 results kept");
        add(0, 5'd17,      16'd20,   "s4 tof1 after abort");
        run_tbl();

        // Asynchronous reset in the middle of LISTEN, during an ack cycle
        cmp = '0;
        add(1, ADR_CTRL, 16'h0003, "s5 start");
        run_tbl();
        pulses(20);
        cmp[0] = 1'b1; pulses(1);
        bus.wb_valid_i = 1'b1; bus.wbs_strb_i = 1'b0; bus.wbs_adr_i = ADR_TICK;
        cyc();
        bus.wb_valid_i = 1'b0;
        chk("s5 ack before rst", 16'(bus.wbs_ack_o), 16'h1);
        chk("s5 tick before rst", bus.wbs_dat_o, 16'd21);
        #2 rst_n = 1'b0;
        #1;
        chk("s5 ack in rst", 16'(bus.wbs_ack_o), 16'h0);
        chk("s5 dat in rst", bus.wbs_dat_o, 16'h0);
        chk("s5 irq in rst", 16'(irq), 16'h0);
        #2 rst_n = 1'b1;
        cmp = '0;
        cyc();
        add_reset_reads("s5");
        run_tbl();

`ifdef SSCS_TOF_AUTO_REARM_EN
        // Continuous mode: DONE lasts one cycle, then a fresh measurement
        add(1, ADR_BLANK,  16'd2,    "s6 blank");
        add(1, ADR_WINDOW, 16'd5,    "s6 window");
        add(1, ADR_CTRL,   16'h0007, "s6 start cont");
        run_tbl();
        pulses(6);
        chk("s6 irq in done", 16'(irq), 16'h1);
        add(0, ADR_CTRL, 16'h0036, "s6 ctrl done");
        add(0, ADR_TICK, 16'h0000, "s6 tick restarted");
        add(0, ADR_CTRL, 16'h0016, "s6 ctrl blanking");
        run_tbl();
`else
        add(1, ADR_CTRL, 16'h0004, "s6 cont wr");
        add(0, ADR_CTRL, 16'h0000, "s6 cont reads 0");
        run_tbl();
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
